// File: rtl/uart_ctrl_if.sv
// Host byte interface of uart_ctrl: TX FIFO write side and RX FIFO read side.
interface uart_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] din;
   logic                  wr_uart;
   logic                  tx_full;
   logic                  tx_empty;
   logic                  rd_uart;
   logic [DATA_WIDTH-1:0] out;
   logic                  rx_empty;
   logic                  rx_full;

   modport master (
      output din, wr_uart, rd_uart,
      input  tx_full, tx_empty, out, rx_empty, rx_full
   );

   modport slave (
      input  din, wr_uart, rd_uart,
      output tx_full, tx_empty, out, rx_empty, rx_full
   );
endinterface

// File: rtl/uart_ctrl.sv
// Full-duplex UART: TX/RX FIFOs, baud tick generator, TX and RX frame FSMs,
// optional parity, one or two stop bits, internal loopback and sticky errors.
module uart_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_ctrl_if.slave           host,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 two_stop,
   input  logic                 loopback,
   output logic                 tx_busy,
   output logic                 tx,
   input  logic                 rx,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   input  logic                 err_clr
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(2 * OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] STOP2_LAST = CW'(2 * OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_WIDTH - 1);
   localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // Baud tick: one cycle every divisor+1 clocks
   logic [DIV_WIDTH-1:0] baud_cnt;
   logic                 tick;
   assign tick = (baud_cnt >= divisor);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) baud_cnt <= '0;
      else        baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
   end

   // TX FIFO
   logic [DATA_WIDTH-1:0] txf_mem [FIFO_DEPTH];
   logic [AW-1:0]         txf_wp, txf_rp;
   logic [AW:0]           txf_cnt;
   logic                  txf_wr, txf_rd, tx_pop;
   logic [DATA_WIDTH-1:0] tx_head;
   assign host.tx_empty = (txf_cnt == '0);
   assign host.tx_full  = (txf_cnt == FULL_CNT);
   assign txf_rd  = tx_pop & ~host.tx_empty;
   assign txf_wr  = host.wr_uart & (~host.tx_full | txf_rd);
   assign tx_head = txf_mem[txf_rp];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         txf_wp <= '0; txf_rp <= '0; txf_cnt <= '0;
      end else begin
         if (txf_wr) txf_wp <= txf_wp + 1'b1;
         if (txf_rd) txf_rp <= txf_rp + 1'b1;
         if (txf_wr && !txf_rd)      txf_cnt <= txf_cnt + 1'b1;
         else if (!txf_wr && txf_rd) txf_cnt <= txf_cnt - 1'b1;
      end
   end
   always_ff @(posedge clk) if (txf_wr) txf_mem[txf_wp] <= host.din;

   // RX FIFO, head presented first-word fall-through
   logic [DATA_WIDTH-1:0] rxf_mem [FIFO_DEPTH];
   logic [AW-1:0]         rxf_wp, rxf_rp;
   logic [AW:0]           rxf_cnt;
   logic                  rxf_wr, rxf_rd, rx_push;
   logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
   assign host.rx_empty = (rxf_cnt == '0);
   assign host.rx_full  = (rxf_cnt == FULL_CNT);
   assign rxf_rd   = host.rd_uart & ~host.rx_empty;
   assign rxf_wr   = rx_push & (~host.rx_full | rxf_rd);
   assign host.out = host.rx_empty ? '0 : rxf_mem[rxf_rp];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxf_wp <= '0; rxf_rp <= '0; rxf_cnt <= '0;
      end else begin
         if (rxf_wr) rxf_wp <= rxf_wp + 1'b1;
         if (rxf_rd) rxf_rp <= rxf_rp + 1'b1;
         if (rxf_wr && !rxf_rd)      rxf_cnt <= rxf_cnt + 1'b1;
         else if (!rxf_wr && rxf_rd) rxf_cnt <= rxf_cnt - 1'b1;
      end
   end
   always_ff @(posedge clk) if (rxf_wr) rxf_mem[rxf_wp] <= rx_shift;

   // TX FSM
   state_t                tx_state, tx_state_n;
   logic [CW-1:0]         tx_tcnt, tx_tcnt_n, tx_stop_last;
   logic [BW-1:0]         tx_bits, tx_bits_n;
   logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;
   logic                  tx_par, tx_par_n, tx_line, tx_line_n;
   assign tx_stop_last = two_stop ? STOP2_LAST : BIT_LAST;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= S_IDLE; tx_tcnt <= '0; tx_bits <= '0; tx_shift <= '0;
         tx_par <= 1'b0; tx_line <= 1'b1; tx <= 1'b1; tx_busy <= 1'b0;
      end else begin
         tx_state <= tx_state_n; tx_tcnt <= tx_tcnt_n; tx_bits <= tx_bits_n;
         tx_shift <= tx_shift_n; tx_par <= tx_par_n; tx_line <= tx_line_n;
         tx <= tx_line_n | loopback;
         tx_busy <= (tx_state_n != S_IDLE);
      end
   end

   always_comb begin
      tx_state_n = tx_state; tx_tcnt_n = tx_tcnt; tx_bits_n = tx_bits;
      tx_shift_n = tx_shift; tx_par_n = tx_par; tx_pop = 1'b0; tx_line_n = 1'b1;
      case (tx_state)
         S_IDLE: if (!host.tx_empty) begin
            tx_pop = 1'b1; tx_shift_n = tx_head; tx_par_n = ^tx_head ^ parity_odd;
            tx_tcnt_n = '0; tx_state_n = S_START;
         end
         S_START: if (tick) begin
            if (tx_tcnt == BIT_LAST) begin
               tx_tcnt_n = '0; tx_bits_n = '0; tx_state_n = S_DATA;
            end else tx_tcnt_n = tx_tcnt + 1'b1;
         end
         S_DATA: if (tick) begin
            if (tx_tcnt == BIT_LAST) begin
               tx_tcnt_n = '0; tx_shift_n = tx_shift >> 1;
               if (tx_bits == DATA_LAST) tx_state_n = parity_en ? S_PARITY : S_STOP;
               else                      tx_bits_n = tx_bits + 1'b1;
            end else tx_tcnt_n = tx_tcnt + 1'b1;
         end
         S_PARITY: if (tick) begin
            if (tx_tcnt == BIT_LAST) begin
               tx_tcnt_n = '0; tx_state_n = S_STOP;
            end else tx_tcnt_n = tx_tcnt + 1'b1;
         end
         S_STOP: if (tick) begin
            if (tx_tcnt == tx_stop_last) begin
               tx_tcnt_n = '0;
               // Chain straight into the next frame when data is waiting
               if (!host.tx_empty) begin
                  tx_pop = 1'b1; tx_shift_n = tx_head; tx_par_n = ^tx_head ^ parity_odd;
                  tx_state_n = S_START;
               end else tx_state_n = S_IDLE;
            end else tx_tcnt_n = tx_tcnt + 1'b1;
         end
         default: tx_state_n = S_IDLE;
      endcase
      case (tx_state_n)
         S_START:  tx_line_n = 1'b0;
         S_DATA:   tx_line_n = tx_shift_n[0];
         S_PARITY: tx_line_n = tx_par_n;
         default:  tx_line_n = 1'b1;
      endcase
   end

   // RX synchronizer and FSM
   logic [1:0]    rx_sync;
   logic          rx_line;
   state_t        rx_state, rx_state_n;
   logic [CW-1:0] rx_tcnt, rx_tcnt_n;
   logic [BW-1:0] rx_bits, rx_bits_n;
   logic          rx_par, rx_par_n, rx_wait, rx_wait_n;
   logic          set_pe, set_fe, set_oe;
   assign rx_line = rx_sync[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_sync <= 2'b11; rx_state <= S_IDLE; rx_tcnt <= '0; rx_bits <= '0;
         rx_shift <= '0; rx_par <= 1'b0; rx_wait <= 1'b0;
         parity_err <= 1'b0; frame_err <= 1'b0; overrun_err <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], loopback ? tx_line : rx};
         rx_state <= rx_state_n; rx_tcnt <= rx_tcnt_n; rx_bits <= rx_bits_n;
         rx_shift <= rx_shift_n; rx_par <= rx_par_n; rx_wait <= rx_wait_n;
         parity_err  <= set_pe | (parity_err  & ~err_clr);
         frame_err   <= set_fe | (frame_err   & ~err_clr);
         overrun_err <= set_oe | (overrun_err & ~err_clr);
      end
   end

   always_comb begin
      rx_state_n = rx_state; rx_tcnt_n = rx_tcnt; rx_bits_n = rx_bits;
      rx_shift_n = rx_shift; rx_par_n = rx_par; rx_wait_n = rx_wait;
      rx_push = 1'b0; set_pe = 1'b0; set_fe = 1'b0; set_oe = 1'b0;
      case (rx_state)
         S_IDLE: begin
            // After a framing error, a start is only accepted once the line has gone high
            if (rx_wait) begin
               if (rx_line) rx_wait_n = 1'b0;
            end else if (!rx_line) begin
               rx_tcnt_n = '0; rx_state_n = S_START;
            end
         end
         S_START: if (tick) begin
            if (rx_tcnt == HALF_LAST) begin
               rx_tcnt_n = '0; rx_bits_n = '0;
               rx_state_n = rx_line ? S_IDLE : S_DATA;
            end else rx_tcnt_n = rx_tcnt + 1'b1;
         end
         S_DATA: if (tick) begin
            if (rx_tcnt == BIT_LAST) begin
               rx_tcnt_n = '0; rx_shift_n = {rx_line, rx_shift[DATA_WIDTH-1:1]};
               if (rx_bits == DATA_LAST) rx_state_n = parity_en ? S_PARITY : S_STOP;
               else                      rx_bits_n = rx_bits + 1'b1;
            end else rx_tcnt_n = rx_tcnt + 1'b1;
         end
         S_PARITY: if (tick) begin
            if (rx_tcnt == BIT_LAST) begin
               rx_tcnt_n = '0; rx_par_n = rx_line; rx_state_n = S_STOP;
            end else rx_tcnt_n = rx_tcnt + 1'b1;
         end
         S_STOP: if (tick) begin
            if (rx_tcnt == BIT_LAST) begin
               rx_tcnt_n = '0; rx_state_n = S_IDLE;
               if (!rx_line) begin
                  set_fe = 1'b1; rx_wait_n = 1'b1;
               end else if (host.rx_full) begin
                  set_oe = 1'b1;
               end else begin
                  rx_push = 1'b1;
                  set_pe  = parity_en & (rx_par != (^rx_shift ^ parity_odd));
               end
            end else rx_tcnt_n = rx_tcnt + 1'b1;
         end
         default: rx_state_n = S_IDLE;
      endcase
   end
endmodule
